// File: rtl/pipe_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit: one bit per cycle on operand
// magnitudes (shift-add / restoring), followed by a single sign-fix cycle.
module pipe_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] resLo,
    output logic [WIDTH-1:0] resHi,
    output logic             divZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       nextState_s;
    logic [CNT_W-1:0] cnt_r;
    logic             isDiv_r;
    logic             signA_r;
    logic             signB_r;
    logic             bZero_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             ready_r;
    logic [WIDTH-1:0] resLo_r;
    logic [WIDTH-1:0] resHi_r;
    logic             divZero_r;

    logic             accept_s;
    logic [WIDTH-1:0] magA_s;
    logic [WIDTH-1:0] magB_s;
    logic [WIDTH:0]   mulSum_s;
    logic [WIDTH:0]   divShift_s;
    logic             divGe_s;
    logic [WIDTH-1:0] hiNext_s;
    logic [WIDTH-1:0] loNext_s;
    logic [2*WIDTH-1:0] prodNeg_s;
    logic [WIDTH-1:0] fixLo_s;
    logic [WIDTH-1:0] fixHi_s;
    logic             fixDz_s;

    assign accept_s = start && !kill && ((state_r == IDLE) || (state_r == DONE));
    // |MIN| lands on 2^(WIDTH-1), which is exactly representable as unsigned.
    assign magA_s   = (op[0] && a[WIDTH-1]) ? negW(a) : a;
    assign magB_s   = (op[0] && b[WIDTH-1]) ? negW(b) : b;

    // Next-state decode; kill always wins over a new start.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) nextState_s = RUN;
                else          nextState_s = IDLE;
            end
            RUN: begin
                if (kill)                   nextState_s = IDLE;
                else if (cnt_r == CNT_LAST) nextState_s = FIX;
                else                        nextState_s = RUN;
            end
            FIX: begin
                if (kill) nextState_s = IDLE;
                else      nextState_s = DONE;
            end
            DONE: begin
                if (accept_s) nextState_s = RUN;
                else          nextState_s = IDLE;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // One iteration: hi:lo is the product shifting right, or remainder:quotient shifting left.
    always_comb begin
        mulSum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, divisor_r} : {(WIDTH+1){1'b0}});
        divShift_s = {hi_r, lo_r[WIDTH-1]};
        divGe_s    = (divShift_s >= {1'b0, divisor_r});
        if (isDiv_r) begin
            if (divGe_s) begin
                hiNext_s = divShift_s[WIDTH-1:0] - divisor_r;
                loNext_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hiNext_s = divShift_s[WIDTH-1:0];
                loNext_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hiNext_s = mulSum_s[WIDTH:1];
            loNext_s = {mulSum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign fix; with a zero divisor the all-ones quotient is kept and the
    // remainder (|a| re-signed) reproduces the original dividend.
    always_comb begin
        prodNeg_s = neg2W({hi_r, lo_r});
        fixLo_s   = lo_r;
        fixHi_s   = hi_r;
        fixDz_s   = 1'b0;
        if (isDiv_r) begin
            fixHi_s = signA_r ? negW(hi_r) : hi_r;
            if (bZero_r) begin
                fixLo_s = {WIDTH{1'b1}};
                fixDz_s = 1'b1;
            end else begin
                fixLo_s = (signA_r ^ signB_r) ? negW(lo_r) : lo_r;
                fixDz_s = 1'b0;
            end
        end else begin
            if (signA_r ^ signB_r) begin
                fixHi_s = prodNeg_s[2*WIDTH-1:WIDTH];
                fixLo_s = prodNeg_s[WIDTH-1:0];
            end else begin
                fixHi_s = hi_r;
                fixLo_s = lo_r;
            end
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            isDiv_r   <= 1'b0;
            signA_r   <= 1'b0;
            signB_r   <= 1'b0;
            bZero_r   <= 1'b0;
            divisor_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
            resLo_r   <= {WIDTH{1'b0}};
            resHi_r   <= {WIDTH{1'b0}};
            divZero_r <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy_r  <= (nextState_s == RUN) || (nextState_s == FIX);
            ready_r <= (nextState_s == DONE);
            if (accept_s) begin
                cnt_r     <= {CNT_W{1'b0}};
                isDiv_r   <= op[1];
                signA_r   <= op[0] & a[WIDTH-1];
                signB_r   <= op[0] & b[WIDTH-1];
                bZero_r   <= (b == {WIDTH{1'b0}});
                divisor_r <= magB_s;
                hi_r      <= {WIDTH{1'b0}};
                lo_r      <= magA_s;
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + CNT_ONE;
                hi_r  <= hiNext_s;
                lo_r  <= loNext_s;
            end
            if ((state_r == FIX) && !kill) begin
                resLo_r   <= fixLo_s;
                resHi_r   <= fixHi_s;
                divZero_r <= fixDz_s;
            end
        end
    end

    assign busy    = busy_r;
    assign ready   = ready_r;
    assign resLo   = resLo_r;
    assign resHi   = resHi_r;
    assign divZero = divZero_r;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Directed bench for pipe_muldiv_unit: a 32-bit instance for latency, signs,
// divide-by-zero, kill and back-to-back cases, plus an 8-bit instance.
module tb_pipe_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start, kill;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, ready, divZero;
    logic [31:0] resLo, resHi;

    logic        start8, kill8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, ready8, divZero8;
    logic [7:0]  resLo8, resHi8;

    int checks = 0;
    int errors = 0;
    int lat, bc, lat2, rdyCnt, k8;

    pipe_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .a(a), .b(b),
        .busy(busy), .ready(ready), .resLo(resLo), .resHi(resHi), .divZero(divZero)
    );

    pipe_muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .kill(kill8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .ready(ready8), .resLo(resLo8), .resHi(resHi8), .divZero(divZero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic startOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until ready (bounded); -1 when ready never shows.
    task automatic waitReady(output int latency, output int busyCycles);
        latency = -1;
        busyCycles = 0;
        for (int k = 0; k < 100; k++) begin
            if (ready) begin
                latency = k;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        start8 = 1'b0; kill8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
        @(negedge clk);
        check("reset_ctrl", {61'd0, busy, ready, divZero}, 64'd0);
        check("reset_res", {resHi, resLo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: mulu max*max, latency and busy length
        startOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitReady(lat, bc);
        check("mulu_latency", 64'(lat), 64'd33);
        check("mulu_busy_cycles", 64'(bc), 64'd33);
        check("mulu_res", {resHi, resLo}, 64'hFFFF_FFFE_0000_0001);
        check("mulu_dz", {63'd0, divZero}, 64'd0);
        @(negedge clk);
        check("ready_one_cycle", {63'd0, ready}, 64'd0);

        // 2: signed multiply and divide
        startOp(2'b01, 32'hFFFF_FFFD, 32'd5);
        waitReady(lat, bc);
        check("muls_res", {resHi, resLo}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        startOp(2'b11, 32'hFFFF_FFF9, 32'd2);
        waitReady(lat, bc);
        check("divs_q", {32'd0, resLo}, {32'd0, 32'hFFFF_FFFD});
        check("divs_r", {32'd0, resHi}, {32'd0, 32'hFFFF_FFFF});
        @(negedge clk);

        // 3: divide by zero, then MIN / -1
        startOp(2'b10, 32'd10, 32'd0);
        waitReady(lat, bc);
        check("divz_latency", 64'(lat), 64'd33);
        check("divz_flag", {63'd0, divZero}, 64'd1);
        check("divz_res", {resHi, resLo}, 64'h0000_000A_FFFF_FFFF);
        @(negedge clk);
        startOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        waitReady(lat, bc);
        check("min_neg1_res", {resHi, resLo}, 64'h0000_0000_8000_0000);
        check("min_neg1_dz", {63'd0, divZero}, 64'd0);
        @(negedge clk);

        // 4: kill mid-operation, and kill with start from IDLE
        startOp(2'b10, 32'd100, 32'd7);
        waitReady(lat, bc);
        check("divu_100_7", {resHi, resLo}, {32'd2, 32'd14});
        @(negedge clk);
        startOp(2'b00, 32'd6, 32'd7);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_low", {63'd0, busy}, 64'd0);
        rdyCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) rdyCnt++;
        end
        check("kill_no_ready", 64'(rdyCnt), 64'd0);
        check("kill_res_kept", {resHi, resLo}, {32'd2, 32'd14});
        start = 1'b1; kill = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_idle", {63'd0, busy}, 64'd0);
        rdyCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) rdyCnt++;
        end
        check("kill_start_no_op", 64'(rdyCnt), 64'd0);

        // 5: back-to-back start on DONE, start ignored while busy
        startOp(2'b00, 32'd2, 32'd3);
        waitReady(lat, bc);
        check("b2b_first_ready", 64'(lat), 64'd33);
        check("b2b_first_res", {32'd0, resLo}, 64'd6);
        startOp(2'b00, 32'd6, 32'd7);
        check("b2b_no_gap", {63'd0, busy}, 64'd1);
        repeat (4) @(negedge clk);
        startOp(2'b00, 32'd3, 32'd3);
        waitReady(lat2, bc);
        check("b2b_latency", 64'(lat2), 64'd28);
        check("b2b_res", {resHi, resLo}, 64'd42);
        @(negedge clk);
        check("busy_start_ignored", {62'd0, busy, ready}, 64'd0);

        // 6: asynchronous reset mid divs, then 8-bit muls MIN*MIN
        startOp(2'b11, 32'hFFFF_FF9C, 32'd7);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_ctrl", {61'd0, busy, ready, divZero}, 64'd0);
        check("arst_res", {resHi, resLo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_idle", {62'd0, busy, ready}, 64'd0);

        start8 = 1'b1; op8 = 2'b01; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        k8 = -1;
        for (int k = 0; k < 40; k++) begin
            if (ready8) begin
                k8 = k;
                break;
            end
            @(negedge clk);
        end
        check("w8_latency", 64'(k8), 64'd9);
        check("w8_res", {48'd0, resHi8, resLo8}, 64'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
